dmem_responder: RTL and testbench

Memory-side responder for the MIPS processor's data-memory port. It accepts single-word load and store requests, inserts a programmable number of wait states, and commits stores to an internal word array. It signals completion with a one-cycle `ready` pulse and returns load data. It replaces the zero-wait combinational data memory under `top` when the core is exercised against a stalling memory.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word RAM with synchronous write and asynchronous read; contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IdxW-1:0]   widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IdxW-1:0]   ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then pulses ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LatInit = LAT_W'(LATENCY);

  dmem_state_t       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              ready_q, ready_d, err_q, err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              capture, commit, cur_we, cur_bad;
  logic [WORD_W-1:0] cur_addr, arr_rdata;

  assign capture = (state_q == IDLE) && req;
  assign commit  = (state_q == RESP) && we_q && !err_q;

  // With zero latency RESP is entered straight from IDLE, so the live inputs
  // stand in for the latched copies that are being written at that same edge.
  assign cur_we   = (state_q == IDLE) ? we : we_q;
  assign cur_addr = (state_q == IDLE) ? addr : addr_q;
  assign cur_bad  = (cur_addr[1:0] != 2'b00) || (cur_addr[WORD_W-1:IdxW+2] != '0);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (commit),
    .widx (addr_q[IdxW+1:2]),
    .wdata(wdata_q),
    .ridx (cur_addr[IdxW+1:2]),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LatInit;
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d    = (state_d == RESP);
    err_d      = ready_d && cur_bad;
    rdata_d    = (ready_d && !cur_we && !cur_bad) ? arr_rdata : '0;
    wr_count_d = (commit && (wr_count_q != 16'hFFFF)) ? wr_count_q + 16'd1 : wr_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wr_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders with latencies 2, 0 and 5 exercised in sequence.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n    [3];
  logic        req      [3];
  logic        we       [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic        ready    [3];
  logic [31:0] rdata    [3];
  logic        err      [3];
  logic [15:0] wr_count [3];

  int unsigned lat [3];
  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]),
    .wr_count(wr_count[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]),
    .wr_count(wr_count[1])
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(5)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2]),
    .wr_count(wr_count[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; optionally scrambles addr/wdata right after acceptance.
  task automatic access(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, input string tag,
                        output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    if (scramble) begin
      addr[i]  = 32'd36;
      wdata[i] = 32'hFF;
    end
    n = 0;
    while (!ready[i] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req[i] = 1'b0;
    check({tag, " latency"}, n, lat[i]);
    rd = rdata[i];
    e  = err[i];
    @(posedge clk); #1;
    check({tag, " pulse"}, {31'd0, ready[i]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          t;
    int          k;
    int          t_ready [3];
    int          seen;

    lat[0] = 2; lat[1] = 0; lat[2] = 5;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset ready", {31'd0, ready[i]}, 32'd0);
      check("reset err", {31'd0, err[i]}, 32'd0);
      check("reset rdata", rdata[i], 32'd0);
      check("reset wr_count", {16'd0, wr_count[i]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Store then load, latency 2
    access(0, 1'b1, 32'd84, 32'd7, 1'b0, "st84", rd, e);
    check("st84 err", {31'd0, e}, 32'd0);
    check("st84 rdata", rd, 32'd0);
    check("st84 wr_count", {16'd0, wr_count[0]}, 32'd1);
    access(0, 1'b0, 32'd84, 32'd0, 1'b0, "ld84", rd, e);
    check("ld84 rdata", rd, 32'd7);
    check("ld84 err", {31'd0, e}, 32'd0);

    // Error responses
    access(0, 1'b1, 32'd86, 32'd99, 1'b0, "st86", rd, e);
    check("st86 err", {31'd0, e}, 32'd1);
    check("st86 rdata", rd, 32'd0);
    access(0, 1'b1, 32'd256, 32'd99, 1'b0, "st256", rd, e);
    check("st256 err", {31'd0, e}, 32'd1);
    check("st256 rdata", rd, 32'd0);
    check("err wr_count", {16'd0, wr_count[0]}, 32'd1);
    access(0, 1'b0, 32'd84, 32'd0, 1'b0, "ld84b", rd, e);
    check("ld84b rdata", rd, 32'd7);
    access(0, 1'b0, 32'd86, 32'd0, 1'b0, "ld86", rd, e);
    check("ld86 err", {31'd0, e}, 32'd1);
    check("ld86 rdata", rd, 32'd0);

    // Input changes during WAIT are ignored
    access(0, 1'b1, 32'd36, 32'h55, 1'b0, "st36", rd, e);
    access(0, 1'b1, 32'd32, 32'd9, 1'b1, "st32", rd, e);
    access(0, 1'b0, 32'd32, 32'd0, 1'b0, "ld32", rd, e);
    check("ld32 rdata", rd, 32'd9);
    access(0, 1'b0, 32'd36, 32'd0, 1'b0, "ld36", rd, e);
    check("ld36 rdata", rd, 32'h55);
    check("dut0 wr_count", {16'd0, wr_count[0]}, 32'd3);

    // Zero latency, back-to-back stores with req held high
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd0; wdata[1] = 32'd1;
    t = 0;
    for (int j = 0; j < 3; j++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        t++; k++;
      end while (!ready[1] && k < 10);
      t_ready[j] = t;
      addr[1]  = 32'(4 * (j + 1));
      wdata[1] = 32'(j + 2);
    end
    req[1] = 1'b0;
    check("b2b ready0 cycle", t_ready[0], 32'd1);
    check("b2b ready1 cycle", t_ready[1], 32'd3);
    check("b2b ready2 cycle", t_ready[2], 32'd5);
    @(posedge clk); #1;
    check("b2b wr_count", {16'd0, wr_count[1]}, 32'd3);
    for (int j = 0; j < 3; j++) begin
      access(1, 1'b0, 32'(4 * j), 32'd0, 1'b0, "b2b load", rd, e);
      check("b2b load rdata", rd, 32'(j + 1));
    end

    // Reset during WAIT, latency 5
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'd16; wdata[2] = 32'hDEAD;
    @(posedge clk); #1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready[2]) seen++;
    end
    rst_n[2] = 1'b0;
    req[2]   = 1'b0;
    #1;
    check("rst ready low", {31'd0, ready[2]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[2]) seen++;
    end
    check("rst no ready", seen, 32'd0);
    check("rst wr_count", {16'd0, wr_count[2]}, 32'd0);
    access(2, 1'b1, 32'd16, 32'd5, 1'b0, "st16", rd, e);
    access(2, 1'b0, 32'd16, 32'd0, 1'b0, "ld16", rd, e);
    check("ld16 rdata", rd, 32'd5);
    check("post-rst wr_count", {16'd0, wr_count[2]}, 32'd1);

    // Saturation
    @(negedge clk);
    force u_dut1.wr_count_q = 16'hFFFE;
    @(negedge clk);
    release u_dut1.wr_count_q;
    @(negedge clk);
    check("sat preset", {16'd0, wr_count[1]}, 32'h0000FFFE);
    access(1, 1'b1, 32'd12, 32'd10, 1'b0, "sat st", rd, e);
    check("sat 1", {16'd0, wr_count[1]}, 32'h0000FFFF);
    access(1, 1'b1, 32'd12, 32'd11, 1'b0, "sat st", rd, e);
    access(1, 1'b1, 32'd12, 32'd12, 1'b0, "sat st", rd, e);
    check("sat hold", {16'd0, wr_count[1]}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
